mdio_peripheral: RTL and testbench

MDIO_PERIPHERAL -- requirements
Module: mdio_peripheral

---
 rtl/mdio_peripheral.sv | 202 ++++++++++++++++++++
 tb/tb_mdio_peripheral.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_peripheral.sv
// mdio_peripheral: Clause-22 MDIO peripheral, MDC used directly as clk.
// Decodes PRE/ST/OP/PHYAD/REGAD/TA/DATA, raises register strobes and
// serialises read data back to the station controller.
// Build option: define MDIO_PREAMBLE_CHECK_EN to require a full 32-bit
// preamble before ST; by default a single 1 suffices (preamble suppression).
`timescale 1ns/1ps

module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [4:0]  addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        rd_stb,
  input  logic [15:0] rd_data,
  output logic        frame_err
);

  localparam int unsigned PRE_W = 6;
  localparam int unsigned CNT_W = 5;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(32);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
  } state_t;

  state_t             r_state;
  logic [PRE_W-1:0]   r_pre_cnt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_op_hi;
  logic               r_is_read;
  logic               r_match;
  logic [4:0]         r_addr_sr;
  logic [15:0]        r_rd_sr;
  logic               r_mdio_out;
  logic               r_mdio_oe;
  logic [4:0]         r_addr;
  logic [15:0]        r_wr_data;
  logic               r_wr_stb;
  logic               r_rd_stb;
  logic               r_frame_err;
  logic               w_pre_ok;
  logic [4:0]         w_addr_next;

  // Preamble qualification for accepting ST
`ifdef MDIO_PREAMBLE_CHECK_EN
  assign w_pre_ok = (r_pre_cnt == PRE_MAX);
`else
  assign w_pre_ok = (r_pre_cnt != '0);
`endif

  assign w_addr_next = {r_addr_sr[3:0], mdio_in};

  // Frame decoder FSM with registered strobes and serial output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pre_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_op_hi     <= 1'b0;
      r_is_read   <= 1'b0;
      r_match     <= 1'b0;
      r_addr_sr   <= '0;
      r_rd_sr     <= '0;
      r_mdio_out  <= 1'b0;
      r_mdio_oe   <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_wr_stb    <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_stb    <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mdio_in) begin
            if (r_pre_cnt != PRE_MAX) r_pre_cnt <= r_pre_cnt + PRE_W'(1);
          end else begin
            r_pre_cnt <= '0;
            if (w_pre_ok) r_state <= S_START;
          end
        end
        S_START: begin
          r_bit_cnt <= '0;
          if (mdio_in) begin
            r_state <= S_OP;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_OP: begin
          if (r_bit_cnt == '0) begin
            r_op_hi   <= mdio_in;
            r_bit_cnt <= CNT_W'(1);
          end else begin
            r_bit_cnt <= '0;
            if (r_op_hi != mdio_in) begin
              r_is_read <= r_op_hi;
              r_state   <= S_PHYAD;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        S_PHYAD: begin
          r_addr_sr <= w_addr_next;
          if (r_bit_cnt == CNT_W'(4)) begin
            r_match   <= (w_addr_next == PHY_ADDR);
            r_bit_cnt <= '0;
            r_state   <= S_REGAD;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        S_REGAD: begin
          r_addr_sr <= w_addr_next;
          if (r_bit_cnt == CNT_W'(4)) begin
            r_addr    <= w_addr_next;
            r_rd_stb  <= r_match & r_is_read;
            r_bit_cnt <= '0;
            r_state   <= S_TA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        S_TA: begin
          if (r_bit_cnt == '0) begin
            // Write turnaround must start with a 1
            if (r_match && !r_is_read && !mdio_in) begin
              r_frame_err <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_bit_cnt <= CNT_W'(1);
            end
          end else begin
            r_bit_cnt <= '0;
            if (r_is_read) begin
              r_state <= S_RDATA;
              if (r_match) begin
                r_rd_sr    <= rd_data;
                r_mdio_oe  <= 1'b1;
                r_mdio_out <= 1'b0;
              end
            end else if (r_match && mdio_in) begin
              r_frame_err <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_state <= S_WDATA;
            end
          end
        end
        S_WDATA: begin
          r_wr_data <= {r_wr_data[14:0], mdio_in};
          if (r_bit_cnt == CNT_W'(15)) begin
            r_wr_stb  <= r_match;
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        S_RDATA: begin
          if (r_bit_cnt != CNT_W'(16)) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_match) begin
              r_mdio_out <= r_rd_sr[15];
              r_rd_sr    <= {r_rd_sr[14:0], 1'b0};
            end
          end else begin
            // Drive ends here; this edge's sample is already the next preamble
            r_mdio_oe  <= 1'b0;
            r_mdio_out <= 1'b0;
            r_bit_cnt  <= '0;
            r_pre_cnt  <= PRE_W'(mdio_in);
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mdio_out  = r_mdio_out;
  assign mdio_oe   = r_mdio_oe;
  assign addr      = r_addr;
  assign wr_data   = r_wr_data;
  assign wr_stb    = r_wr_stb;
  assign rd_stb    = r_rd_stb;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_mdio_peripheral.sv
// tb_mdio_peripheral: directed MDIO frames; expected events are queued by the
// driver and checked in order (with cycle stamp) by an independent monitor.
`timescale 1ns/1ps

module tb_mdio_peripheral;

  localparam int K_WR  = 1;
  localparam int K_RD  = 2;
  localparam int K_ERR = 3;
  localparam int K_RDO = 4;

`ifdef MDIO_PREAMBLE_CHECK_EN
  localparam bit SHORT_PRE_OK = 1'b0;
`else
  localparam bit SHORT_PRE_OK = 1'b1;
`endif

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic [4:0]  addr;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        rd_stb;
  logic [15:0] rd_data;
  logic        frame_err;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic [15:0] rd_resp = 16'h0000;
  ev_t         exp_q[$];
  int          oe_cnt = 0;
  logic [31:0] oe_bits = '0;

  mdio_peripheral #(.PHY_ADDR(5'd1)) dut (
    .clk       (clk),
    .reset     (reset),
    .mdio_in   (mdio_in),
    .mdio_out  (mdio_out),
    .mdio_oe   (mdio_oe),
    .addr      (addr),
    .wr_data   (wr_data),
    .wr_stb    (wr_stb),
    .rd_stb    (rd_stb),
    .rd_data   (rd_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Register-file stand-in: data becomes valid the cycle after rd_stb
  always @(negedge clk) begin
    if (reset && rd_stb) begin
      @(posedge clk);
      #1;
      rd_data = rd_resp;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    checks = checks + 1;
    if (exp_q.size() == 0) begin
      failures = failures + 1;
      $display("FAIL unexpected_event: got kind=%0d a=%0h d=%0h cyc=%0d expected none",
               kind, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a !== a || e.d !== d || e.cyc != cyc) begin
        failures = failures + 1;
        $display("FAIL event: got kind=%0d a=%0h d=%0h cyc=%0d expected kind=%0d a=%0h d=%0h cyc=%0d",
                 kind, a, d, cyc, e.kind, e.a, e.d, e.cyc);
      end
    end
  endtask

  // Monitor: turns DUT outputs into events and compares against the queue
  always @(negedge clk) begin
    if (!reset) begin
      oe_cnt  = 0;
      oe_bits = '0;
    end else begin
      if (wr_stb)    check_ev(K_WR, 32'(addr), 32'(wr_data));
      if (rd_stb)    check_ev(K_RD, 32'(addr), 32'h0);
      if (frame_err) check_ev(K_ERR, 32'h0, 32'h0);
      if (mdio_oe) begin
        oe_bits = {oe_bits[30:0], mdio_out};
        oe_cnt  = oe_cnt + 1;
      end else if (oe_cnt != 0) begin
        check_ev(K_RDO, 32'(oe_cnt), oe_bits);
        oe_cnt  = 0;
        oe_bits = '0;
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    mdio_in  = b;
    last_cyc = cyc + 1;
  endtask

  task automatic send_ones(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  // Drives one frame after ST and queues the responses a correct peripheral gives
  task automatic frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rega,
                       input logic [1:0] ta, input logic [15:0] data, input bit accept,
                       input int abort_bits);
    bit match;
    bit is_rd;
    match = accept && (phy == 5'd1);
    is_rd = (op == 2'b10);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(op[1]);
    send_bit(op[0]);
    if (op == 2'b00 || op == 2'b11) begin
      if (accept) push(K_ERR, last_cyc, 32'h0, 32'h0);
      return;
    end
    for (int i = 4; i >= 0; i--) send_bit(phy[i]);
    for (int i = 4; i >= 0; i--) send_bit(rega[i]);
    if (is_rd) begin
      rd_data = 16'h0000;
      rd_resp = data;
      if (match) push(K_RD, last_cyc, 32'(rega), 32'h0);
      send_bit(ta[1]);
      send_bit(ta[0]);
      if (match && abort_bits < 0) push(K_RDO, last_cyc + 17, 32'd17, 32'(data));
      send_ones(abort_bits < 0 ? 16 : abort_bits);
    end else begin
      send_bit(ta[1]);
      if (match && !ta[1]) begin
        push(K_ERR, last_cyc, 32'h0, 32'h0);
        return;
      end
      send_bit(ta[0]);
      if (match && ta[0]) begin
        push(K_ERR, last_cyc, 32'h0, 32'h0);
        return;
      end
      for (int i = 15; i >= 0; i--) send_bit(data[i]);
      if (match) push(K_WR, last_cyc, 32'(rega), 32'(data));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    mdio_in = 1'b1;
    rd_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_oe",      32'(mdio_oe),   32'h0);
    chk("reset_out",     32'(mdio_out),  32'h0);
    chk("reset_addr",    32'(addr),      32'h0);
    chk("reset_wr_data", 32'(wr_data),   32'h0);
    chk("reset_wr_stb",  32'(wr_stb),    32'h0);
    chk("reset_rd_stb",  32'(rd_stb),    32'h0);
    chk("reset_err",     32'(frame_err), 32'h0);
    reset = 1'b1;

    // Matched write
    send_ones(32);
    frame(2'b01, 5'd1, 5'h0A, 2'b10, 16'hBEEF, 1'b1, -1);
    // Matched read
    send_ones(32);
    frame(2'b10, 5'd1, 5'h03, 2'b11, 16'hA5C3, 1'b1, -1);
    // Unmatched write followed by a matched one
    send_ones(32);
    frame(2'b01, 5'd2, 5'h07, 2'b10, 16'h5555, 1'b1, -1);
    send_ones(32);
    frame(2'b01, 5'd1, 5'h07, 2'b10, 16'h1234, 1'b1, -1);
    // Malformed: OP=11, then write with TA=00
    send_ones(32);
    frame(2'b11, 5'd1, 5'h04, 2'b10, 16'h0000, 1'b1, -1);
    send_ones(32);
    frame(2'b01, 5'd1, 5'h05, 2'b00, 16'hFFFF, 1'b1, -1);
    // Short preamble
    send_ones(8);
    frame(2'b01, 5'd1, 5'h11, 2'b10, 16'hC0DE, SHORT_PRE_OK, -1);
    // Reset during read data
    send_ones(32);
    frame(2'b10, 5'd1, 5'h03, 2'b11, 16'h1357, 1'b1, 4);
    #1;
    chk("oe_before_reset", 32'(mdio_oe), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("oe_in_reset",   32'(mdio_oe),  32'h0);
    chk("out_in_reset",  32'(mdio_out), 32'h0);
    chk("addr_in_reset", 32'(addr),     32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_ones(32);
    frame(2'b01, 5'd1, 5'h1F, 2'b10, 16'h0F0F, 1'b1, -1);
    send_ones(6);
    chk("addr_hold",    32'(addr),    32'h1F);
    chk("wr_data_hold", 32'(wr_data), 32'h0F0F);
    chk("queue_empty",  32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
